challenge_arg_deser: RTL and testbench

CHALLENGE_ARG_DESER -- requirements
Module: challenge_arg_deser

---
 rtl/challenge_pkg.sv | 14 +
 rtl/challenge_arg_deser.sv | 179 +++++++++++++++++
 tb/tb_challenge_arg_deser.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/challenge_pkg.sv
// Shared definitions for the challenge argument deserializer.
package challenge_pkg;

  localparam int FLEN_DEFAULT = 64;
  localparam int ERR_CNT_W    = 16;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    GET_C = 2'd2,
    DROP  = 2'd3
  } state_e;

endpackage

// File: rtl/challenge_arg_deser.sv
// Deserializes a stream of operand words (a, b, c) into one parallel triple
// for the formula pipeline. Optional framing check on in_last is enabled by
// defining ARG_DESER_FRAME_CHECK_EN; the default build ignores in_last.
//
// state | meaning
// GET_A | waiting for the a word, stored in hold_a
// GET_B | waiting for the b word, stored in hold_b
// GET_C | waiting for the c word, commits a/b/c to the output registers
// DROP  | discarding words of a bad frame until in_last (frame check only)
module challenge_arg_deser
  import challenge_pkg::*;
#(
  parameter int FLEN = FLEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [FLEN-1:0]      in_data,
  input  logic                 in_last,
  output logic                 arg_vld,
  input  logic                 arg_rdy,
  output logic [FLEN-1:0]      a,
  output logic [FLEN-1:0]      b,
  output logic [FLEN-1:0]      c,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e          state_q, state_d;
  logic [FLEN-1:0] hold_a_q, hold_a_d;
  logic [FLEN-1:0] hold_b_q, hold_b_d;
  logic [FLEN-1:0] a_q, a_d;
  logic [FLEN-1:0] b_q, b_d;
  logic [FLEN-1:0] c_q, c_d;
  logic            vld_q, vld_d;
  logic            in_xfer;

`ifdef ARG_DESER_FRAME_CHECK_EN
  logic                 ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
`else
  logic                 unused_in_last;
  assign unused_in_last = in_last;
`endif

  // Input acceptance: a and b are always taken; c only when the output slot frees up.
  always_comb begin
    if (rst) begin
      in_rdy = 1'b0;
    end else if (state_q == GET_C) begin
      in_rdy = !vld_q || arg_rdy;
    end else begin
      in_rdy = 1'b1;
    end
  end

  assign in_xfer = in_vld && in_rdy;

  // Next-state logic for the framing FSM, hold registers and output triple.
  always_comb begin
    state_d  = state_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    vld_d    = vld_q && !arg_rdy;
`ifdef ARG_DESER_FRAME_CHECK_EN
    ferr_d   = 1'b0;
`endif
    case (state_q)
      GET_A: begin
        if (in_xfer) begin
`ifdef ARG_DESER_FRAME_CHECK_EN
          if (in_last) begin
            ferr_d = 1'b1;
          end else
`endif
          begin
            hold_a_d = in_data;
            state_d  = GET_B;
          end
        end
      end
      GET_B: begin
        if (in_xfer) begin
`ifdef ARG_DESER_FRAME_CHECK_EN
          if (in_last) begin
            ferr_d  = 1'b1;
            state_d = GET_A;
          end else
`endif
          begin
            hold_b_d = in_data;
            state_d  = GET_C;
          end
        end
      end
      GET_C: begin
        if (in_xfer) begin
`ifdef ARG_DESER_FRAME_CHECK_EN
          if (!in_last) begin
            ferr_d  = 1'b1;
            state_d = DROP;
          end else
`endif
          begin
            a_d     = hold_a_q;
            b_d     = hold_b_q;
            c_d     = in_data;
            vld_d   = 1'b1;
            state_d = GET_A;
          end
        end
      end
`ifdef ARG_DESER_FRAME_CHECK_EN
      DROP: begin
        if (in_xfer && in_last) begin
          state_d = GET_A;
        end
      end
`endif
      default: state_d = GET_A;
    endcase
`ifdef ARG_DESER_FRAME_CHECK_EN
    cnt_d = cnt_q;
    if (ferr_d && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GET_A;
      hold_a_q <= '0;
      hold_b_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      vld_q    <= vld_d;
    end
  end

`ifdef ARG_DESER_FRAME_CHECK_EN
  // Framing error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ferr_q <= ferr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign frame_err = ferr_q;
  assign err_cnt   = cnt_q;
`else
  assign frame_err = 1'b0;
  assign err_cnt   = '0;
`endif

  assign arg_vld = vld_q;
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;

endmodule

// File: tb/tb_challenge_arg_deser.sv
// Testbench for challenge_arg_deser: directed scenarios plus randomized
// traffic, checked cycle by cycle against a word-list reference model.
module tb_challenge_arg_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_data;
  logic        in_last;
  logic        arg_vld;
  logic        arg_rdy;
  logic [63:0] a, b, c;
  logic        frame_err;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  challenge_arg_deser #(.FLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
    .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } trip_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  trip_t       expq[$];
  logic [63:0] part[$];
  bit          drop;
  bit          ferr_pend;
  int          ecnt;
  int          pops;
  int          stall_seen;
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: words collected into a list; a complete triple becomes
  // one pending output.
  task automatic accept(input logic [63:0] w, input bit l);
    trip_t t;
`ifdef ARG_DESER_FRAME_CHECK_EN
    if (drop) begin
      if (l) drop = 0;
    end else if (part.size() < 2) begin
      if (l) begin
        part.delete();
        ferr_pend = 1;
        if (ecnt < 65535) ecnt++;
      end else begin
        part.push_back(w);
      end
    end else begin
      if (l) begin
        t.a = part[0]; t.b = part[1]; t.c = w;
        expq.push_back(t);
      end else begin
        ferr_pend = 1;
        if (ecnt < 65535) ecnt++;
        drop = 1;
      end
      part.delete();
    end
`else
    part.push_back(w);
    if (part.size() == 3) begin
      t.a = part[0]; t.b = part[1]; t.c = part[2];
      expq.push_back(t);
      part.delete();
    end
`endif
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit l, input bit r);
    bit pend;
    bit exp_rdy;
    bit ferr_now;
    in_vld  = v;
    in_data = d;
    in_last = l;
    arg_rdy = r;
    #1;
    ferr_now  = ferr_pend;
    ferr_pend = 0;
    chk("frame_err", {63'd0, frame_err}, {63'd0, ferr_now});
    chk("err_cnt", {48'd0, err_cnt}, 64'(ecnt));
    pend = (expq.size() != 0);
    chk("arg_vld", {63'd0, arg_vld}, {63'd0, pend});
    if (pend) begin
      chk("out_a", a, expq[0].a);
      chk("out_b", b, expq[0].b);
      chk("out_c", c, expq[0].c);
    end
    if (!drop && part.size() == 2) exp_rdy = !pend || r;
    else exp_rdy = 1;
    chk("in_rdy", {63'd0, in_rdy}, {63'd0, exp_rdy});
    if (!exp_rdy) stall_seen++;
    if (pend && r) begin
      void'(expq.pop_front());
      pops++;
    end
    last_acc = v && exp_rdy;
    if (last_acc) accept(d, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1;
    in_vld  = 0;
    in_last = 0;
    arg_rdy = 0;
    #1;
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_arg_vld", {63'd0, arg_vld}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_c", c, 64'd0);
    expq.delete();
    part.delete();
    drop      = 0;
    ferr_pend = 0;
    ecnt      = 0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] cw;
    bit          cv, cl;
    int          gpos;

    rst = 1; in_vld = 0; in_data = '0; in_last = 0; arg_rdy = 0;
    @(negedge clk);
    do_reset();

    // Basic triple 1.0, 2.0, 3.0
    step(1, $realtobits(1.0), 0, 1);
    step(1, $realtobits(2.0), 0, 1);
    step(1, $realtobits(3.0), 1, 1);
    #1;
    chk("t029_a", a, $realtobits(1.0));
    chk("t029_c", c, $realtobits(3.0));
    step(0, '0, 0, 1);

    // Back-to-back streaming: 10 triples, no bubbles
    pops = 0;
    for (int i = 0; i < 30; i++) step(1, rnd64(), (i % 3) == 2, 1);
    step(0, '0, 0, 1);
    chk("t030_triples", 64'(pops), 64'd10);

    // Output back-pressure while the next a, b are collected
    stall_seen = 0;
    pops = 0;
    step(1, 64'h1111, 0, 0);
    step(1, 64'h2222, 0, 0);
    step(1, 64'h3333, 1, 0);
    step(1, 64'h4444, 0, 0);
    step(1, 64'h5555, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 64'h6666, 1, 0);
    step(1, 64'h6666, 1, 1);
    step(0, '0, 0, 1);
    chk("t031_stalls", 64'(stall_seen), 64'd6);
    chk("t031_triples", 64'(pops), 64'd2);

    // Reset with a, b collected and a pending output
    step(1, 64'hA1, 0, 0);
    step(1, 64'hB1, 0, 0);
    step(1, 64'hC1, 1, 0);
    step(1, 64'hA2, 0, 0);
    step(1, 64'hB2, 0, 0);
    do_reset();
    step(1, 64'hA3, 0, 1);
    step(1, 64'hB3, 0, 1);
    step(1, 64'hC3, 1, 1);
    #1;
    chk("t034_b", b, 64'hB3);
    step(0, '0, 0, 1);

`ifdef ARG_DESER_FRAME_CHECK_EN
    // in_last on b word, then clean triple 4.0, 5.0, 6.0
    pops = 0;
    step(1, $realtobits(7.0), 0, 1);
    step(1, $realtobits(8.0), 1, 1);
    step(1, $realtobits(4.0), 0, 1);
    step(1, $realtobits(5.0), 0, 1);
    step(1, $realtobits(6.0), 1, 1);
    #1;
    chk("t032_err_cnt", {48'd0, err_cnt}, 64'd1);
    chk("t032_c", c, $realtobits(6.0));
    step(0, '0, 0, 1);
    chk("t032_triples", 64'(pops), 64'd1);

    // c word without in_last, then two dropped words, then a clean triple
    pops = 0;
    step(1, 64'h10, 0, 1);
    step(1, 64'h20, 0, 1);
    step(1, 64'h30, 0, 1);
    step(1, 64'h40, 0, 1);
    step(1, 64'h50, 1, 1);
    step(1, 64'h60, 0, 1);
    step(1, 64'h70, 0, 1);
    step(1, 64'h80, 1, 1);
    step(0, '0, 0, 1);
    chk("t033_err_cnt", {48'd0, err_cnt}, 64'd2);
    chk("t033_triples", 64'(pops), 64'd1);
`endif

    // Randomized traffic with held words until accepted
    gpos = 0;
    cv = ($urandom_range(0, 9) < 7);
    cw = rnd64();
    cl = ((gpos % 3) == 2) ^ ($urandom_range(0, 9) == 0);
    for (int i = 0; i < 400; i++) begin
      step(cv, cw, cl, $urandom_range(0, 9) < 6);
      if (last_acc) gpos++;
      if (last_acc || !cv) begin
        cv = ($urandom_range(0, 9) < 7);
        cw = rnd64();
        cl = ((gpos % 3) == 2) ^ ($urandom_range(0, 9) == 0);
      end
    end
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
